sram_sp_be_regbased: RTL and testbench

- Register-array single-port SRAM model with per-column write enables, SIZE words of DATA_WD bits each.
- Used as the leaf storage bank under multi-bank wrappers. Each bank gets shared address and data; write/read valids are gated per bank by the wrapper.
- Optional output register adds one cycle of read latency.

---
 rtl/sram_sp_be_regbased.sv | 116 +++++++++++
 tb/tb_sram_sp_be_regbased.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_be_regbased.sv
// Purpose : register-array single-port SRAM bank with per-column write enables.
// Latency : read data 1 cycle after request (KNOB_REGOUT=0) or 2 cycles (KNOB_REGOUT=1).
// Backpressure: none; every read/write request is accepted the cycle it is presented.
//
// Optional feature: define SRAM_SP_BE_WR_FIRST_EN for write-through on a same-cycle
// read/write to one address (enabled columns come from wr_dat_i). Default is read-first.
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset (clears memory and read pipeline)
//   adr_i     word address shared by read and write
//   wr_val_i  per-column write enable, bit k covers wr_dat_i[k*SIZE_COL +: SIZE_COL]
//   wr_dat_i  write data
//   rd_val_i  read request
//   rd_val_o  read data valid, one-cycle pulse per request
//   rd_dat_o  read data, holds until the next read completes
module sram_sp_be_regbased #(
  parameter int KNOB_REGOUT = 0,   // legal values: 0 or 1
  parameter int SIZE        = 64,
  parameter int SIZE_COL    = 8,
  parameter int DATA_WD     = 32,
  localparam int SIZE_WD    = $clog2(SIZE),
  localparam int NUM_COL    = DATA_WD / SIZE_COL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SIZE_WD-1:0] adr_i,
  input  logic [NUM_COL-1:0] wr_val_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  input  logic               rd_val_i,
  output logic               rd_val_o,
  output logic [DATA_WD-1:0] rd_dat_o
);

  // SIZE always fits in SIZE_WD+1 bits, so the range check needs no 32-bit compare.
  localparam logic [SIZE_WD:0] SIZE_L = SIZE[SIZE_WD:0];

  logic [DATA_WD-1:0] mem [SIZE];
  logic               adr_ok;
  logic [DATA_WD-1:0] rd_word;
  logic               s1_vld;
  logic [DATA_WD-1:0] s1_dat;

  // Non-power-of-two SIZE leaves a hole at the top of the address space.
  assign adr_ok = ({1'b0, adr_i} < SIZE_L);

  // Word presented to the read pipeline; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (adr_ok) begin
      rd_word = mem[adr_i];
`ifdef SRAM_SP_BE_WR_FIRST_EN
      for (int k = 0; k < NUM_COL; k++) begin
        if (wr_val_i[k]) begin
          rd_word[k*SIZE_COL +: SIZE_COL] = wr_dat_i[k*SIZE_COL +: SIZE_COL];
        end
      end
`endif
    end
  end

  // Storage: column-masked write, ignored for out-of-range addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (adr_ok) begin
      for (int k = 0; k < NUM_COL; k++) begin
        if (wr_val_i[k]) begin
          mem[adr_i][k*SIZE_COL +: SIZE_COL] <= wr_dat_i[k*SIZE_COL +: SIZE_COL];
        end
      end
    end
  end

  // Stage 1: captures the word only on a request so data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_val_i;
      if (rd_val_i) begin
        s1_dat <= rd_word;
      end
    end
  end

  generate
    if (KNOB_REGOUT == 1) begin : g_regout
      logic               s2_vld;
      logic [DATA_WD-1:0] s2_dat;

      // Stage 2 loads only behind a valid stage-1 entry.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_dat <= s1_dat;
          end
        end
      end

      assign rd_val_o = s2_vld;
      assign rd_dat_o = s2_dat;
    end else begin : g_noregout
      assign rd_val_o = s1_vld;
      assign rd_dat_o = s1_dat;
    end
  endgenerate

endmodule

// File: tb/tb_sram_sp_be_regbased.sv
module tb_sram_sp_be_regbased;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  adr;
  logic [3:0]  wr_val;
  logic [31:0] wr_dat;
  logic        rd_val;

  logic        r0_val, r1_val, np_val;
  logic [31:0] r0_dat, r1_dat, np_dat;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Latency-1 bank, latency-2 bank, and a non-power-of-two bank (SIZE=5).
  sram_sp_be_regbased #(.KNOB_REGOUT(0), .SIZE(64), .SIZE_COL(8), .DATA_WD(32)) u_r0 (
    .clk(clk), .rst(rst), .adr_i(adr), .wr_val_i(wr_val), .wr_dat_i(wr_dat),
    .rd_val_i(rd_val), .rd_val_o(r0_val), .rd_dat_o(r0_dat));

  sram_sp_be_regbased #(.KNOB_REGOUT(1), .SIZE(64), .SIZE_COL(8), .DATA_WD(32)) u_r1 (
    .clk(clk), .rst(rst), .adr_i(adr), .wr_val_i(wr_val), .wr_dat_i(wr_dat),
    .rd_val_i(rd_val), .rd_val_o(r1_val), .rd_dat_o(r1_dat));

  sram_sp_be_regbased #(.KNOB_REGOUT(0), .SIZE(5), .SIZE_COL(8), .DATA_WD(32)) u_np (
    .clk(clk), .rst(rst), .adr_i(adr[2:0]), .wr_val_i(wr_val), .wr_dat_i(wr_dat),
    .rd_val_i(rd_val), .rd_val_o(np_val), .rd_dat_o(np_dat));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_val = 4'b0000;
    wr_dat = '0;
    rd_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    adr = '0;
    idle();
    step();
    step();
    check("rst_r0_val", {31'b0, r0_val}, 32'd0);
    check("rst_r0_dat", r0_dat, 32'h0);
    check("rst_r1_val", {31'b0, r1_val}, 32'd0);
    check("rst_r1_dat", r1_dat, 32'h0);
    rst = 1'b0;

    // Read of reset memory.
    adr = 6'd5; rd_val = 1'b1;
    step();
    idle();
    check("rd5_r0_val", {31'b0, r0_val}, 32'd1);
    check("rd5_r0_dat", r0_dat, 32'h0);
    check("rd5_r1_early", {31'b0, r1_val}, 32'd0);
    step();
    check("rd5_r0_pulse", {31'b0, r0_val}, 32'd0);
    check("rd5_r1_val", {31'b0, r1_val}, 32'd1);
    check("rd5_r1_dat", r1_dat, 32'h0);

    // Full write then read.
    adr = 6'd3; wr_val = 4'b1111; wr_dat = 32'hA5A5_1234;
    step();
    idle();
    rd_val = 1'b1;
    step();
    idle();
    check("wr3_r0_val", {31'b0, r0_val}, 32'd1);
    check("wr3_r0_dat", r0_dat, 32'hA5A5_1234);
    step();
    check("wr3_r0_once", {31'b0, r0_val}, 32'd0);
    check("wr3_r0_hold", r0_dat, 32'hA5A5_1234);

    // Column-masked write: columns 0 and 2 only.
    wr_val = 4'b0101; wr_dat = 32'hFFFF_FFFF;
    step();
    idle();
    rd_val = 1'b1;
    step();
    idle();
    check("mask_r0_dat", r0_dat, 32'hA5FF_12FF);

    // Preload adr 0,1,2 then pipelined reads through the latency-2 bank.
    adr = 6'd0; wr_val = 4'b1111; wr_dat = 32'h1000_0000;
    step();
    adr = 6'd1; wr_dat = 32'h2000_0001;
    step();
    adr = 6'd2; wr_dat = 32'h3000_0002;
    step();
    idle();
    adr = 6'd0; rd_val = 1'b1;
    step();
    check("pipe_r0_a0", r0_dat, 32'h1000_0000);
    check("pipe_r1_wait", {31'b0, r1_val}, 32'd0);
    adr = 6'd1;
    step();
    check("pipe_r1_v0", {31'b0, r1_val}, 32'd1);
    check("pipe_r1_a0", r1_dat, 32'h1000_0000);
    check("pipe_r0_a1", r0_dat, 32'h2000_0001);
    adr = 6'd2;
    step();
    idle();
    check("pipe_r1_v1", {31'b0, r1_val}, 32'd1);
    check("pipe_r1_a1", r1_dat, 32'h2000_0001);
    step();
    check("pipe_r1_v2", {31'b0, r1_val}, 32'd1);
    check("pipe_r1_a2", r1_dat, 32'h3000_0002);
    step();
    check("pipe_r1_done", {31'b0, r1_val}, 32'd0);
    check("pipe_r1_hold", r1_dat, 32'h3000_0002);

    // Same-cycle read and write to one address.
    adr = 6'd7; wr_val = 4'b1111; wr_dat = 32'h1111_1111;
    step();
    wr_dat = 32'hDEAD_BEEF; rd_val = 1'b1;
    step();
    idle();
`ifdef SRAM_SP_BE_WR_FIRST_EN
    check("rw7_r0_dat", r0_dat, 32'hDEAD_BEEF);
`else
    check("rw7_r0_dat", r0_dat, 32'h1111_1111);
`endif
    rd_val = 1'b1;
    step();
    idle();
    check("rw7_after", r0_dat, 32'hDEAD_BEEF);

    // Non-power-of-two bank: top valid word and an out-of-range address.
    adr = 6'd4; wr_val = 4'b1111; wr_dat = 32'hCAFE_F00D;
    step();
    idle();
    rd_val = 1'b1;
    step();
    idle();
    check("np4_val", {31'b0, np_val}, 32'd1);
    check("np4_dat", np_dat, 32'hCAFE_F00D);
    adr = 6'd6; wr_val = 4'b1111; wr_dat = 32'h1234_5678;
    step();
    idle();
    rd_val = 1'b1;
    step();
    idle();
    check("np6_val", {31'b0, np_val}, 32'd1);
    check("np6_dat", np_dat, 32'h0);
    check("r0_6_dat", r0_dat, 32'h1234_5678);

    // Reset while a read is in flight in the latency-2 bank.
    adr = 6'd3; rd_val = 1'b1;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstfl_r1_val", {31'b0, r1_val}, 32'd0);
    check("rstfl_r1_dat", r1_dat, 32'h0);
    step();
    check("rstfl_r1_late", {31'b0, r1_val}, 32'd0);
    rd_val = 1'b1;
    step();
    idle();
    check("rstfl_mem_r0", r0_dat, 32'h0);
    check("rstfl_mem_v", {31'b0, r0_val}, 32'd1);
    step();
    check("rstfl_mem_r1", r1_dat, 32'h0);
    check("rstfl_mem_r1v", {31'b0, r1_val}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
